// File: rtl/digit_demux_pkg.sv
// rtl/digit_demux_pkg.sv - shared defaults and index width for the digit demux bank
package digit_demux_pkg;
   localparam int N_CH_DEF     = 9;
   localparam int DW_DEF       = 4;
   localparam int SCAN_DIV_DEF = 1000;
   localparam int IDX_W        = 4;
endpackage

// File: rtl/digit_demux_bank_if.sv
// rtl/digit_demux_bank_if.sv - write/scan signal bundle between a host and digit_demux_bank
import digit_demux_pkg::*;

interface digit_demux_bank_if #(
   parameter int N_CH = N_CH_DEF,
   parameter int DW   = DW_DEF
);
   logic               wr_en_i;
   logic [IDX_W-1:0]   sel_i;
   logic [DW-1:0]      data_i;
   logic               clr_i;
   logic [N_CH*DW-1:0] sal_o;
   logic               wr_ack_o;
   logic               wr_err_o;
   logic [N_CH-1:0]    chg_o;
   logic [IDX_W-1:0]   scan_idx_o;
   logic [DW-1:0]      scan_data_o;

   modport master (
      output wr_en_i, sel_i, data_i, clr_i,
      input  sal_o, wr_ack_o, wr_err_o, chg_o, scan_idx_o, scan_data_o
   );

   modport slave (
      input  wr_en_i, sel_i, data_i, clr_i,
      output sal_o, wr_ack_o, wr_err_o, chg_o, scan_idx_o, scan_data_o
   );
endinterface

// File: rtl/digit_demux_bank_scan_prescaler.sv
// rtl/digit_demux_bank_scan_prescaler.sv - scan prescaler and wrapping channel index
import digit_demux_pkg::*;

module scan_prescaler #(
   parameter int N_CH     = N_CH_DEF,
   parameter int SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             step_o,
   output logic [IDX_W-1:0] idx_o
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;

   assign step_o = (cnt == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt   <= '0;
         idx_o <= '0;
      end else if (step_o) begin
         cnt   <= '0;
         idx_o <= (idx_o == IDX_W'(N_CH - 1)) ? '0 : idx_o + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/digit_demux_bank.sv
// rtl/digit_demux_bank.sv - indexed channel register bank with change flags
// Scanner (scan_idx_o/scan_data_o, chg_o auto-clear) built only with DIGIT_DEMUX_SCAN_EN.
import digit_demux_pkg::*;

module digit_demux_bank #(
   parameter int N_CH     = N_CH_DEF,
   parameter int DW       = DW_DEF,
   parameter int SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   digit_demux_bank_if.slave bus
);
   logic [DW-1:0]   ch [N_CH];
   logic [N_CH-1:0] chg;
   logic            wr_ack;
   logic            wr_err;
   logic            in_range;
   logic            accept;
   logic            reject;

   // Extra MSB keeps the compare correct when N_CH equals 16.
   assign in_range = ({1'b0, bus.sel_i} < (IDX_W + 1)'(N_CH));
   assign accept   = bus.wr_en_i && in_range && !bus.clr_i;
   assign reject   = bus.wr_en_i && !in_range && !bus.clr_i;

`ifdef DIGIT_DEMUX_SCAN_EN
   logic             step;
   logic [IDX_W-1:0] scan_idx;
   logic [DW-1:0]    cur_data;
   logic [DW-1:0]    scan_data;

   scan_prescaler #(
      .N_CH     (N_CH),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .step_o (step),
      .idx_o  (scan_idx)
   );

   always_comb begin
      cur_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (scan_idx == IDX_W'(k)) cur_data = ch[k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) scan_data <= '0;
      else       scan_data <= cur_data;
   end

   assign bus.scan_idx_o  = scan_idx;
   assign bus.scan_data_o = scan_data;
`else
   assign bus.scan_idx_o  = '0;
   assign bus.scan_data_o = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < N_CH; k++) ch[k] <= '0;
         chg    <= '0;
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_ack <= accept;
         wr_err <= reject;
         if (bus.clr_i) begin
            for (int k = 0; k < N_CH; k++) ch[k] <= '0;
            chg <= '0;
         end else begin
`ifdef DIGIT_DEMUX_SCAN_EN
            // Clear the flag of the channel being left; a same-cycle write below wins.
            for (int k = 0; k < N_CH; k++) begin
               if (step && scan_idx == IDX_W'(k)) chg[k] <= 1'b0;
            end
`endif
            for (int k = 0; k < N_CH; k++) begin
               if (accept && bus.sel_i == IDX_W'(k)) begin
                  ch[k]  <= bus.data_i;
                  chg[k] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_sal
      assign bus.sal_o[g*DW +: DW] = ch[g];
   end

   assign bus.chg_o    = chg;
   assign bus.wr_ack_o = wr_ack;
   assign bus.wr_err_o = wr_err;
endmodule

// File: doc/digit_demux_bank.md
DIGIT_DEMUX_BANK -- requirements
Module: digit_demux_bank

Interface
REQ-001 SHALL have parameter N_CH, default 9, number of output channels (2..16).
REQ-002 SHALL have parameter DW, default 4, channel data width in bits (1..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clk_i cycles per scan step (>=2).
REQ-004 SHALL have port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en_i  in  1  write request, one write per asserted cycle.
REQ-007 SHALL have port sel_i  in  4  target channel index.
REQ-008 SHALL have port data_i  in  DW  write data.
REQ-009 SHALL have port clr_i  in  1  synchronous clear of all channels.
REQ-010 SHALL have port sal_o  out  N_CH*DW  flattened channel registers; channel k at bits [k*DW +: DW].
REQ-011 SHALL have port wr_ack_o  out  1  one-cycle pulse, accepted write.
REQ-012 SHALL have port wr_err_o  out  1  one-cycle pulse, rejected write (sel_i >= N_CH).
REQ-013 SHALL have port chg_o  out  N_CH  per-channel "written since last scanned" flags.
REQ-014 SHALL have port scan_idx_o  out  4  channel currently presented by the scanner.
REQ-015 SHALL have port scan_data_o  out  DW  content of channel scan_idx_o.

Function
REQ-016 SHALL, on wr_en_i=1 and sel_i<N_CH, load data_i into channel sel_i at that edge; all other channels hold.
REQ-017 SHALL assert wr_ack_o for exactly the cycle after an accepted write; back-to-back writes give back-to-back acks.
REQ-018 SHALL, on wr_en_i=1 and sel_i>=N_CH, leave all channels and chg_o unchanged and pulse wr_err_o the following cycle.
REQ-019 SHALL, on clr_i=1, zero every channel and chg_o; clr_i overrides a same-cycle write, which gets neither ack nor err.
REQ-020 SHALL set chg_o[sel_i] on an accepted write.
REQ-021 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count scan_idx_o advances by 1, wrapping N_CH-1 -> 0.
REQ-022 SHALL present scan_data_o as a registered copy of the channel at scan_idx_o, so it reflects a write one cycle after sal_o does.
REQ-023 SHALL clear chg_o[scan_idx_o] at each scan step (the channel being left); a write to that channel in the same cycle keeps the flag set (write wins).
REQ-024 SHALL never let scan_idx_o take a value >= N_CH.

Reset
REQ-025 SHALL, while rst_i=1, force sal_o=0, chg_o=0, wr_ack_o=0, wr_err_o=0, scan_idx_o=0, scan_data_o=0, prescaler=0, independent of clk_i.
REQ-026 SHALL abort any in-flight ack/err pulse on reset; nothing pending is emitted after deassertion.
REQ-027 SHALL resume scanning at index 0 with a full SCAN_DIV period after rst_i deasserts.

Configuration
REQ-028 SHALL compile the scanner (REQ-021..REQ-024, scan outputs, chg_o clearing) only when macro DIGIT_DEMUX_SCAN_EN is defined.
REQ-029 SHALL, without DIGIT_DEMUX_SCAN_EN, tie scan_idx_o and scan_data_o to 0, omit the prescaler, and let chg_o flags clear only via clr_i or reset.

Structure
REQ-030 SHALL place default N_CH, DW, SCAN_DIV and the index width constant (4) in shared package digit_demux_pkg.
REQ-031 SHALL implement the prescaler and index counter as sub-module scan_prescaler (clk_i, rst_i, step pulse, index out).

Verification
REQ-032 SHALL cover: reset, write sel=3 data=7 -> sal_o ch3=7, wr_ack_o high one cycle later, other channels 0, chg_o=9'b000001000.
REQ-033 SHALL cover: wr_en_i with sel=12, N_CH=9 -> wr_err_o one-cycle pulse, sal_o and chg_o unchanged, no ack.
REQ-034 SHALL cover: clr_i and write sel=2 data=5 same cycle -> all channels 0, no ack, no err.
REQ-035 SHALL cover: SCAN_DIV=4, ch8=9 -> scan_idx_o steps every 4 cycles, 8 -> 0 wrap; scan_data_o=9 while index 8; chg_o[8] cleared on leaving 8.
REQ-036 SHALL cover: rst_i asserted mid-scan (index 5) and same cycle as wr_ack_o pulse -> all outputs 0 immediately, index restarts at 0 after SCAN_DIV cycles.
REQ-037 SHALL cover: build without DIGIT_DEMUX_SCAN_EN -> scan outputs stay 0 for 3*SCAN_DIV cycles, chg_o bits persist until clr_i.
